// File: rtl/axis_fifo_pkg.sv
// Shared types and constants for the FIFO read-side AXI-Stream drainer.
package axis_fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int AXIS_DATA_W = 16;
    localparam int PKT_COUNT_W = 16;
    localparam int OCC_W       = 2;

    // Width of a modulo-len counter; a one-beat packet still needs one bit.
    function automatic int cnt_width(input int len);
        return (len > 1) ? $clog2(len) : 1;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry output buffer: a head entry that drives the stream and a skid
// entry that absorbs one extra word while the consumer stalls.
module axis_skid_buf
    import axis_fifo_pkg::*;
#(
    parameter int ENTRY_W = AXIS_DATA_W + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    output logic [ENTRY_W-1:0] head_data,
    output logic               head_valid,
    output logic [OCC_W-1:0]   occ
);

    logic [ENTRY_W-1:0] head_q, head_d;
    logic [ENTRY_W-1:0] skid_q, skid_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic               valid_q, valid_d;

    // Next-entry and occupancy update; a push is only offered while occ < 2.
    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        occ_d  = occ_q;
        case (occ_q)
            2'd0: begin
                if (push) begin
                    head_d = push_data;
                    occ_d  = 2'd1;
                end else begin
                    occ_d  = 2'd0;
                end
            end
            2'd1: begin
                case ({push, pop})
                    2'b11: head_d = push_data;
                    2'b10: begin
                        skid_d = push_data;
                        occ_d  = 2'd2;
                    end
                    2'b01: occ_d = 2'd0;
                    default: occ_d = 2'd1;
                endcase
            end
            2'd2: begin
                if (pop) begin
                    head_d = skid_q;
                    occ_d  = 2'd1;
                end else begin
                    occ_d  = 2'd2;
                end
            end
            default: occ_d = 2'd0;
        endcase
        valid_d = (occ_d != 2'd0);
    end

    // Buffer registers; reset discards every buffered word.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= {ENTRY_W{1'b0}};
            skid_q  <= {ENTRY_W{1'b0}};
            occ_q   <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            skid_q  <= skid_d;
            occ_q   <= occ_d;
            valid_q <= valid_d;
        end
    end

    assign head_data  = head_q;
    assign head_valid = valid_q;
    assign occ        = occ_q;

endmodule

// File: rtl/axis_fifo_reader.sv
// Drains the CDC FIFO read port into an AXI-Stream master.
// Packet framing (tlast, pkt_count, DRAIN state) exists only when the
// macro AXIS_FIFO_READER_TLAST_EN is defined; otherwise tlast and
// pkt_count are tied low and dropping enable stops popping at once.
module axis_fifo_reader
    import axis_fifo_pkg::*;
#(
    parameter int DATA_W  = AXIS_DATA_W,
    parameter int PKT_LEN = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   fifo_empty,
    output logic                   rd_en,
    input  logic [DATA_W-1:0]      rd_data,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [DATA_W-1:0]      m_axis_tdata,
    output logic                   m_axis_tlast,
    output logic [PKT_COUNT_W-1:0] pkt_count,
    output logic                   busy
);

`ifdef AXIS_FIFO_READER_TLAST_EN
    localparam int ENTRY_W = DATA_W + 1;
`else
    localparam int ENTRY_W = DATA_W;
`endif

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic [OCC_W-1:0]   occ_s, occ_next_s;
    logic               valid_s;
    logic               hs_s;
    logic [ENTRY_W-1:0] push_entry_s;
    logic [ENTRY_W-1:0] head_entry_s;

    assign hs_s = valid_s && m_axis_tready;

    axis_skid_buf #(.ENTRY_W(ENTRY_W)) u_buf (
        .clk        (clk),
        .reset      (reset),
        .push       (rd_en),
        .push_data  (push_entry_s),
        .pop        (hs_s),
        .head_data  (head_entry_s),
        .head_valid (valid_s),
        .occ        (occ_s)
    );

    // Pop request: never looks at tready, so a full buffer always blocks.
    always_comb begin
        rd_en = 1'b0;
        if (!fifo_empty && (occ_s != 2'd2) &&
            ((state_q == ST_RUN) || (state_q == ST_DRAIN))) begin
            rd_en = 1'b1;
        end else begin
            rd_en = 1'b0;
        end
    end

`ifdef AXIS_FIFO_READER_TLAST_EN
    localparam int              CNT_W    = cnt_width(PKT_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PKT_LEN - 1);

    logic [CNT_W-1:0]       pop_cnt_q, pop_cnt_d;
    logic [PKT_COUNT_W-1:0] pkt_count_q, pkt_count_d;
    logic                   tag_last_s;

    // Tag tlast at pop time and advance the per-packet pop counter.
    always_comb begin
        tag_last_s  = (pop_cnt_q == LAST_CNT);
        pop_cnt_d   = pop_cnt_q;
        pkt_count_d = pkt_count_q;
        if (rd_en) begin
            if (tag_last_s) begin
                pop_cnt_d = {CNT_W{1'b0}};
            end else begin
                pop_cnt_d = pop_cnt_q + CNT_W'(1);
            end
        end else begin
            pop_cnt_d = pop_cnt_q;
        end
        if (hs_s && head_entry_s[DATA_W]) begin
            pkt_count_d = pkt_count_q + PKT_COUNT_W'(1);
        end else begin
            pkt_count_d = pkt_count_q;
        end
    end

    // Framing counters; reset starts a fresh packet.
    always_ff @(posedge clk) begin
        if (reset) begin
            pop_cnt_q   <= {CNT_W{1'b0}};
            pkt_count_q <= {PKT_COUNT_W{1'b0}};
        end else begin
            pop_cnt_q   <= pop_cnt_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    assign push_entry_s = {tag_last_s, rd_data};
    assign m_axis_tlast = head_entry_s[DATA_W];
    assign pkt_count    = pkt_count_q;
`else
    assign push_entry_s = rd_data;
    assign m_axis_tlast = 1'b0;
    assign pkt_count    = {PKT_COUNT_W{1'b0}};
`endif

    // Popping state machine; buffered beats drain regardless of state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_RUN;
                else        state_d = ST_IDLE;
            end
`ifdef AXIS_FIFO_READER_TLAST_EN
            ST_RUN: begin
                if (enable)                          state_d = ST_RUN;
                else if (pop_cnt_q == {CNT_W{1'b0}}) state_d = ST_IDLE;
                else                                 state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (enable)                   state_d = ST_RUN;
                else if (rd_en && tag_last_s) state_d = ST_IDLE;
                else                          state_d = ST_DRAIN;
            end
`else
            ST_RUN: begin
                if (enable) state_d = ST_RUN;
                else        state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    // Look-ahead occupancy so busy can be registered without lagging.
    always_comb begin
        occ_next_s = occ_s;
        case ({rd_en, hs_s})
            2'b10:   occ_next_s = occ_s + 2'd1;
            2'b01:   occ_next_s = occ_s - 2'd1;
            default: occ_next_s = occ_s;
        endcase
        busy_d = (state_d != ST_IDLE) || (occ_next_s != 2'd0);
    end

    // State and busy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

    assign m_axis_tvalid = valid_s;
    assign m_axis_tdata  = head_entry_s[DATA_W-1:0];
    assign busy          = busy_q;

endmodule

// File: tb/tb_axis_fifo_reader.sv
// Directed bench for axis_fifo_reader (PKT_LEN=8 plus a PKT_LEN=1 instance).
// Expectations follow AXIS_FIFO_READER_TLAST_EN when it is defined.
module tb_axis_fifo_reader;

`ifdef AXIS_FIFO_READER_TLAST_EN
    localparam bit TL = 1'b1;
`else
    localparam bit TL = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, enable, fifo_empty, rd_en;
    logic [15:0] rd_data, m_axis_tdata, pkt_count;
    logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, busy;

    logic        enable1, fifo_empty1, rd_en1, tready1;
    logic [15:0] rd_data1, tdata1, pkt_count1;
    logic        tvalid1, tlast1, busy1;

    axis_fifo_reader #(.DATA_W(16), .PKT_LEN(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .fifo_empty(fifo_empty),
        .rd_en(rd_en), .rd_data(rd_data), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tlast(m_axis_tlast), .pkt_count(pkt_count), .busy(busy)
    );

    axis_fifo_reader #(.DATA_W(16), .PKT_LEN(1)) dut1 (
        .clk(clk), .reset(reset), .enable(enable1), .fifo_empty(fifo_empty1),
        .rd_en(rd_en1), .rd_data(rd_data1), .m_axis_tvalid(tvalid1),
        .m_axis_tready(tready1), .m_axis_tdata(tdata1),
        .m_axis_tlast(tlast1), .pkt_count(pkt_count1), .busy(busy1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // FIFO model, occupancy model and beat collectors.
    logic [15:0] fq[$];
    bit          gate;
    int          pop_total, cyc, occ_m, cnt1;
    bit          pop_pending, hs_pending, pop1_pending;
    logic [15:0] rx_d[$];
    logic        rx_l[$];
    int          rx_c[$];
    logic [15:0] rx1_d[$];
    logic        rx1_l[$];
    int          stab_err, valid_err, occ2_err, occ2_seen;
    bit          hold_v;
    logic [15:0] hold_d;
    logic        hold_l;

    task automatic refresh();
        fifo_empty  = gate || (fq.size() == 0);
        rd_data     = (fq.size() != 0) ? fq[0] : 16'h0000;
        fifo_empty1 = (cnt1 >= 4);
        rd_data1    = 16'(cnt1 + 1);
    endtask

    always @(posedge clk) begin
        cyc++;
        if (reset) occ_m = 0;
        else       occ_m = occ_m + (pop_pending ? 1 : 0) - (hs_pending ? 1 : 0);
        if (pop_pending) begin
            void'(fq.pop_front());
            pop_total++;
        end
        if (pop1_pending) cnt1++;
        #1 refresh();
    end

    always @(negedge clk) begin
        if (hold_v && (!m_axis_tvalid || m_axis_tdata !== hold_d || m_axis_tlast !== hold_l))
            stab_err++;
        hold_v = m_axis_tvalid && !m_axis_tready && !reset;
        hold_d = m_axis_tdata;
        hold_l = m_axis_tlast;
        if (!reset && (m_axis_tvalid !== (occ_m != 0))) valid_err++;
        if (occ_m == 2 && rd_en) occ2_err++;
        if (occ_m == 2) occ2_seen++;
        pop_pending = rd_en && !fifo_empty && !reset;
        hs_pending  = m_axis_tvalid && m_axis_tready && !reset;
        if (hs_pending) begin
            rx_d.push_back(m_axis_tdata);
            rx_l.push_back(m_axis_tlast);
            rx_c.push_back(cyc);
        end
        pop1_pending = rd_en1 && !fifo_empty1 && !reset;
        if (tvalid1 && tready1 && !reset) begin
            rx1_d.push_back(tdata1);
            rx1_l.push_back(tlast1);
        end
    end

    task automatic clear_rx();
        rx_d.delete(); rx_l.delete(); rx_c.delete();
        rx1_d.delete(); rx1_l.delete();
        stab_err = 0; valid_err = 0; occ2_err = 0; occ2_seen = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; enable = 1'b0; enable1 = 1'b0; m_axis_tready = 1'b0;
        gate = 1'b1; fq.delete(); cnt1 = 0; refresh();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; gate = 1'b0; clear_rx(); refresh();
    endtask

    task automatic load(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) fq.push_back(base + 16'(i));
        refresh();
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (rx_d.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_pops(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (pop_total >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        do_reset();
        load(16'h00AA, 1);
        @(negedge clk);
        n_checks += 6;
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
        if (m_axis_tdata !== 16'h0000) begin n_fail++; $display("FAIL reset_tdata: got %h want 0000", m_axis_tdata); end
        if (m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
        if (rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", rd_en); end
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (pkt_count !== 16'd0) begin n_fail++; $display("FAIL reset_pkt_count: got %0d want 0", pkt_count); end
    endtask

    task automatic test_continuous();
        bit ok;
        int c0;
        do_reset();
        load(16'h0001, 16);
        m_axis_tready = 1'b1; enable = 1'b1; c0 = cyc;
        wait_rx(16, 60, ok);
        n_checks++;
        if (!ok || rx_d.size() != 16) begin n_fail++; $display("FAIL cont_beats: got %0d want 16", rx_d.size()); end
        for (int i = 0; i < rx_d.size(); i++) begin
            n_checks += 3;
            if (rx_d[i] !== 16'(i + 1)) begin n_fail++; $display("FAIL cont_data[%0d]: got %h want %h", i, rx_d[i], 16'(i + 1)); end
            if (rx_l[i] !== (TL && (i == 7 || i == 15))) begin n_fail++; $display("FAIL cont_tlast[%0d]: got %b", i, rx_l[i]); end
            // enable edge -> RUN, next edge pops, beat handshakes one cycle later
            if (rx_c[i] != c0 + 2 + i) begin n_fail++; $display("FAIL cont_cycle[%0d]: got %0d want %0d", i, rx_c[i], c0 + 2 + i); end
        end
        n_checks++;
        if (pkt_count !== (TL ? 16'd2 : 16'd0)) begin n_fail++; $display("FAIL cont_pkt_count: got %0d", pkt_count); end
        enable = 1'b0;
        load(16'h0077, 2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks += 2;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL cont_idle_busy: got %b want 0", busy); end
        if (rd_en !== 1'b0) begin n_fail++; $display("FAIL cont_idle_rd_en: got %b want 0", rd_en); end
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        load(16'h0101, 16);
        m_axis_tready = 1'b1; enable = 1'b1; ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            m_axis_tready = ~m_axis_tready;
            if (rx_d.size() >= 16) begin ok = 1'b1; break; end
        end
        n_checks++;
        if (!ok || rx_d.size() != 16) begin n_fail++; $display("FAIL bp_beats: got %0d want 16", rx_d.size()); end
        for (int i = 0; i < rx_d.size(); i++) begin
            n_checks += 2;
            if (rx_d[i] !== 16'h0101 + 16'(i)) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", i, rx_d[i], 16'h0101 + 16'(i)); end
            if (rx_l[i] !== (TL && (i == 7 || i == 15))) begin n_fail++; $display("FAIL bp_tlast[%0d]: got %b", i, rx_l[i]); end
        end
        n_checks += 5;
        if (stab_err != 0) begin n_fail++; $display("FAIL bp_stable: got %0d violations want 0", stab_err); end
        if (occ2_err != 0) begin n_fail++; $display("FAIL bp_rd_en_full: got %0d pops at occ 2 want 0", occ2_err); end
        if (valid_err != 0) begin n_fail++; $display("FAIL bp_tvalid: got %0d mismatches want 0", valid_err); end
        if (occ2_seen == 0) begin n_fail++; $display("FAIL bp_full_reached: got 0 cycles at occ 2 want >0"); end
        if (pkt_count !== (TL ? 16'd2 : 16'd0)) begin n_fail++; $display("FAIL bp_pkt_count: got %0d", pkt_count); end
        m_axis_tready = 1'b1; enable = 1'b0;
    endtask

    task automatic test_disable_mid();
        bit ok;
        int p0, n;
        do_reset();
        load(16'h0201, 20);
        m_axis_tready = 1'b1; enable = 1'b1; p0 = pop_total;
        wait_pops(p0 + 3, 20, ok);
        enable = 1'b0;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL dis_start: got %0d pops want 3", pop_total - p0); end
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk); #1;
            if (busy === 1'b0) begin ok = 1'b1; break; end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n = rx_d.size();
        n_checks += 5;
        if (!ok) begin n_fail++; $display("FAIL dis_idle: got busy %b want 0", busy); end
        if (pop_total - p0 != (TL ? 8 : 4)) begin n_fail++; $display("FAIL dis_pops: got %0d want %0d", pop_total - p0, TL ? 8 : 4); end
        if (rd_en !== 1'b0 || fifo_empty !== 1'b0) begin n_fail++; $display("FAIL dis_rd_en: got rd_en %b empty %b want 0 0", rd_en, fifo_empty); end
        if (n != (TL ? 8 : 4) || rx_l[n - 1] !== TL || rx_d[n - 1] !== 16'h0200 + 16'(n)) begin
            n_fail++; $display("FAIL dis_last_beat: got %0d beats last %h/%b", n, rx_d[n - 1], rx_l[n - 1]);
        end
        if (pkt_count !== (TL ? 16'd1 : 16'd0)) begin n_fail++; $display("FAIL dis_pkt_count: got %0d", pkt_count); end
    endtask

    task automatic test_fifo_empty();
        bit ok;
        int p0;
        do_reset();
        load(16'h0301, 5);
        m_axis_tready = 1'b1; enable = 1'b1; p0 = pop_total;
        wait_pops(p0 + 5, 20, ok);
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks += 3;
        if (!ok) begin n_fail++; $display("FAIL empty_pops: got %0d want 5", pop_total - p0); end
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL empty_tvalid: got %b want 0", m_axis_tvalid); end
        if (busy !== 1'b1) begin n_fail++; $display("FAIL empty_busy: got %b want 1", busy); end
        @(posedge clk); #1;
        load(16'h0306, 3);
        wait_rx(8, 30, ok);
        n_checks += 2;
        if (!ok || rx_d.size() != 8) begin n_fail++; $display("FAIL empty_beats: got %0d want 8", rx_d.size()); end
        if (pkt_count !== (TL ? 16'd1 : 16'd0)) begin n_fail++; $display("FAIL empty_pkt_count: got %0d", pkt_count); end
        for (int i = 0; i < rx_d.size(); i++) begin
            n_checks += 2;
            if (rx_d[i] !== 16'h0301 + 16'(i)) begin n_fail++; $display("FAIL empty_data[%0d]: got %h", i, rx_d[i]); end
            if (rx_l[i] !== (TL && i == 7)) begin n_fail++; $display("FAIL empty_tlast[%0d]: got %b", i, rx_l[i]); end
        end
        enable = 1'b0;
    endtask

    task automatic test_pkt_len1();
        bit ok;
        do_reset();
        enable1 = 1'b1; ok = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (rx1_d.size() >= 4) begin ok = 1'b1; break; end
        end
        repeat (4) @(posedge clk);
        #1;
        n_checks += 2;
        if (!ok || rx1_d.size() != 4) begin n_fail++; $display("FAIL len1_beats: got %0d want 4", rx1_d.size()); end
        if (pkt_count1 !== (TL ? 16'd4 : 16'd0)) begin n_fail++; $display("FAIL len1_pkt_count: got %0d", pkt_count1); end
        for (int i = 0; i < rx1_d.size(); i++) begin
            n_checks += 2;
            if (rx1_d[i] !== 16'(i + 1)) begin n_fail++; $display("FAIL len1_data[%0d]: got %h", i, rx1_d[i]); end
            if (rx1_l[i] !== TL) begin n_fail++; $display("FAIL len1_tlast[%0d]: got %b want %b", i, rx1_l[i], TL); end
        end
        enable1 = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int p0;
        do_reset();
        load(16'h0401, 32);
        m_axis_tready = 1'b1; enable = 1'b1; p0 = pop_total;
        wait_pops(p0 + 12, 40, ok);
        m_axis_tready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        // 13 pops: pop_cnt = 5, beats 12 and 13 buffered, one packet complete
        n_checks += 3;
        if (!ok || pop_total - p0 != 13) begin n_fail++; $display("FAIL rmid_pops: got %0d want 13", pop_total - p0); end
        if (rd_en !== 1'b0 || m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL rmid_full: got rd_en %b tvalid %b want 0 1", rd_en, m_axis_tvalid); end
        if (pkt_count !== (TL ? 16'd1 : 16'd0)) begin n_fail++; $display("FAIL rmid_pre_pkt: got %0d", pkt_count); end
        @(posedge clk); #1;
        reset = 1'b1; gate = 1'b1; refresh();
        @(posedge clk);
        @(negedge clk);
        n_checks += 3;
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rmid_tvalid: got %b want 0", m_axis_tvalid); end
        if (pkt_count !== 16'd0) begin n_fail++; $display("FAIL rmid_pkt_count: got %0d want 0", pkt_count); end
        if (m_axis_tdata !== 16'h0000) begin n_fail++; $display("FAIL rmid_tdata: got %h want 0000", m_axis_tdata); end
        @(posedge clk); #1;
        reset = 1'b0; gate = 1'b0; fq.delete(); clear_rx();
        load(16'h0501, 16);
        m_axis_tready = 1'b1; enable = 1'b1;
        wait_rx(8, 40, ok);
        n_checks++;
        if (!ok || rx_d.size() < 8) begin n_fail++; $display("FAIL rmid_beats: got %0d want 8", rx_d.size()); end
        for (int i = 0; i < 8 && i < rx_d.size(); i++) begin
            n_checks += 2;
            if (rx_d[i] !== 16'h0501 + 16'(i)) begin n_fail++; $display("FAIL rmid_data[%0d]: got %h", i, rx_d[i]); end
            if (rx_l[i] !== (TL && i == 7)) begin n_fail++; $display("FAIL rmid_tlast[%0d]: got %b", i, rx_l[i]); end
        end
        enable = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; enable1 = 1'b0; m_axis_tready = 1'b0;
        tready1 = 1'b1; gate = 1'b1; cnt1 = 0;
        pop_total = 0; cyc = 0; occ_m = 0;
        refresh();
        test_reset();
        test_continuous();
        test_backpressure();
        test_disable_mid();
        test_fifo_empty();
        test_pkt_len1();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
